// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - sequential 32-bit multiply/divide unit; divider datapath built only with MUL_DIV_UNIT_DIVIDER_EN
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  operation,
    input  logic [31:0] leftOperand,
    input  logic [31:0] rightOperand,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        divisionByZero
);
    typedef enum logic [1:0] {IDLE, RUN, FINISH, DONE} state_t;

    localparam logic [2:0] OP_MUL = 3'd0;
    localparam logic [2:0] OP_DIV = 3'd2;
    localparam logic [2:0] OP_REM = 3'd4;

    state_t      state;
    logic [4:0]  count;
    logic        neg_q;
    logic [31:0] operand_q;
    logic [63:0] acc;

    logic        is_signed_in;
    logic        is_div_in;
    logic        reserved_in;
    logic        left_neg;
    logic        right_neg;
    logic        sign_in;
    logic [31:0] left_mag;
    logic [31:0] right_mag;
    logic        short_path;
    logic        dbz_in;
    logic [32:0] mul_sum;
    logic [31:0] final_sel;

    assign is_signed_in = (operation == OP_MUL) || (operation == OP_DIV) || (operation == OP_REM);
    assign is_div_in    = (operation >= 3'd2) && (operation <= 3'd5);
    assign reserved_in  = operation[2] & operation[1];
    assign left_neg     = is_signed_in & leftOperand[31];
    assign right_neg    = is_signed_in & rightOperand[31];
    assign left_mag     = left_neg  ? (~leftOperand  + 32'd1) : leftOperand;
    assign right_mag    = right_neg ? (~rightOperand + 32'd1) : rightOperand;
    assign sign_in      = (operation == OP_REM) ? left_neg : (left_neg ^ right_neg);

    // Shift-add: acc high word accumulates, low word holds the multiplier shifting out LSB first.
    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand_q} : 33'd0);

`ifdef MUL_DIV_UNIT_DIVIDER_EN
    localparam logic [2:0] OP_REMU = 3'd5;

    logic [2:0]  op_q;
    logic [31:0] rem_q;
    logic [33:0] div_diff;
    logic        div_borrow;
    logic        is_mul_q;

    // Restoring step: trial-subtract divisor from {remainder, next dividend bit}.
    assign div_diff   = {1'b0, rem_q, acc[31]} - {2'b00, operand_q};
    assign div_borrow = div_diff[33];
    assign is_mul_q   = (op_q[2:1] == 2'b00);
    assign short_path = reserved_in | (is_div_in & (rightOperand == 32'd0));
    assign dbz_in     = is_div_in & (rightOperand == 32'd0);
    assign final_sel  = ((op_q == OP_REM) || (op_q == OP_REMU)) ? rem_q : acc[31:0];
`else
    assign short_path = reserved_in | is_div_in;
    assign dbz_in     = 1'b0;
    assign final_sel  = acc[31:0];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            result         <= 32'd0;
            divisionByZero <= 1'b0;
            count          <= 5'd0;
            neg_q          <= 1'b0;
            operand_q      <= 32'd0;
            acc            <= 64'd0;
`ifdef MUL_DIV_UNIT_DIVIDER_EN
            op_q           <= 3'd0;
            rem_q          <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy           <= 1'b1;
                        count          <= 5'd0;
                        result         <= 32'd0;
                        divisionByZero <= dbz_in;
                        neg_q          <= sign_in;
`ifdef MUL_DIV_UNIT_DIVIDER_EN
                        op_q           <= operation;
                        rem_q          <= 32'd0;
`endif
                        if (is_div_in) begin
                            operand_q <= right_mag;
                            acc       <= {32'd0, left_mag};
                        end else begin
                            operand_q <= left_mag;
                            acc       <= {32'd0, right_mag};
                        end
                        state <= short_path ? DONE : RUN;
                    end
                end
                RUN: begin
                    count <= count + 5'd1;
`ifdef MUL_DIV_UNIT_DIVIDER_EN
                    if (is_mul_q) begin
                        acc <= {mul_sum, acc[31:1]};
                    end else begin
                        rem_q      <= div_borrow ? {rem_q[30:0], acc[31]} : div_diff[31:0];
                        acc[31:0]  <= {acc[30:0], ~div_borrow};
                    end
`else
                    acc <= {mul_sum, acc[31:1]};
`endif
                    if (count == 5'd31) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    result <= neg_q ? (~final_sel + 32'd1) : final_sel;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    // Short path enters with done low and raises it here; normal path leaves.
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  operation;
    logic [31:0] leftOperand;
    logic [31:0] rightOperand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        divisionByZero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .operation      (operation),
        .leftOperand    (leftOperand),
        .rightOperand   (rightOperand),
        .busy           (busy),
        .done           (done),
        .result         (result),
        .divisionByZero (divisionByZero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] l, input logic [31:0] r,
                                  output logic [31:0] res, output logic dbz, output int lat);
        int sl;
        int sr;
        sl  = l;
        sr  = r;
        res = 32'd0;
        dbz = 1'b0;
        lat = 2;
        if (op <= 3'd1) begin
            res = l * r;
            lat = 34;
        end else if (op <= 3'd5) begin
`ifdef MUL_DIV_UNIT_DIVIDER_EN
            if (r == 32'd0) begin
                dbz = 1'b1;
            end else begin
                lat = 34;
                case (op)
                    3'd2: res = (l == 32'h80000000 && r == 32'hffffffff) ? 32'h80000000 : sl / sr;
                    3'd3: res = l / r;
                    3'd4: res = (l == 32'h80000000 && r == 32'hffffffff) ? 32'd0 : sl % sr;
                    default: res = l % r;
                endcase
            end
`endif
        end
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] l, input logic [31:0] r,
                          input logic [31:0] eres, input logic edbz, input int elat, input int inject);
        exp_t e;
        int   lat;
        bit   got;
        bit   busy_ok;
        bit   extra;
        e.res = eres;
        e.dbz = edbz;
        e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1; operation = op; leftOperand = l; rightOperand = r;
        @(posedge clk);
        #1;
        start = 1'b0; operation = 3'($urandom); leftOperand = $urandom; rightOperand = $urandom;
        lat = 0; got = 1'b0; busy_ok = 1'b1;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (inject != 0 && lat == inject) begin
                start = 1'b1; operation = 3'd1; leftOperand = 32'd2; rightOperand = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) got = 1'b1;
            else if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = 1'b0;
        e = sb.pop_front();
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        chk({tag, " latency"}, lat, e.lat);
        chk({tag, " result"}, result, e.res);
        chk({tag, " dbz"}, 32'(divisionByZero), 32'(e.dbz));
        chk({tag, " busy_while_running"}, 32'(busy_ok), 32'd1);
        chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, " result_held"}, result, e.res);
        if (inject != 0) begin
            extra = 1'b0;
            repeat (40) begin
                @(negedge clk);
                if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
            end
            chk({tag, " no_second_done"}, 32'(extra), 32'd0);
            chk({tag, " result_after_idle"}, result, e.res);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rl;
        logic [31:0] rr;
        logic [31:0] mres;
        logic        mdbz;
        int          mlat;

        reset = 1'b0; start = 1'b0; operation = 3'd0; leftOperand = 32'd0; rightOperand = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset dbz", 32'(divisionByZero), 32'd0);
        reset = 1'b1;

        run_op("mul_signed", 3'd0, 32'h00000007, 32'hfffffffd, 32'hffffffeb, 1'b0, 34, 0);
        run_op("mulu_max",   3'd1, 32'hffffffff, 32'hffffffff, 32'h00000001, 1'b0, 34, 0);
        run_op("mul_minint", 3'd0, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0, 34, 0);
`ifdef MUL_DIV_UNIT_DIVIDER_EN
        run_op("divu",       3'd3, 32'hc0000000, 32'h00000010, 32'h0c000000, 1'b0, 34, 0);
        run_op("div_neg",    3'd2, 32'hfffffff9, 32'h00000002, 32'hfffffffd, 1'b0, 34, 0);
        run_op("rem_neg",    3'd4, 32'hfffffff9, 32'h00000002, 32'hffffffff, 1'b0, 34, 0);
        run_op("div_ovf",    3'd2, 32'h80000000, 32'hffffffff, 32'h80000000, 1'b0, 34, 0);
        run_op("div_zero",   3'd2, 32'h12345678, 32'h00000000, 32'h00000000, 1'b1, 2, 0);
        run_op("remu",       3'd5, 32'd100,      32'd7,        32'd2,        1'b0, 34, 0);
        run_op("busy_prot",  3'd3, 32'd100,      32'd7,        32'h0000000e, 1'b0, 34, 10);
`else
        run_op("divu",       3'd3, 32'hc0000000, 32'h00000010, 32'h00000000, 1'b0, 2, 0);
        run_op("div_neg",    3'd2, 32'hfffffff9, 32'h00000002, 32'h00000000, 1'b0, 2, 0);
        run_op("rem_neg",    3'd4, 32'hfffffff9, 32'h00000002, 32'h00000000, 1'b0, 2, 0);
        run_op("div_zero",   3'd2, 32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 2, 0);
        run_op("busy_prot",  3'd1, 32'd5,        32'd7,        32'h00000023, 1'b0, 34, 10);
`endif
        run_op("reserved6",  3'd6, 32'h12345678, 32'h00000003, 32'h00000000, 1'b0, 2, 0);
        run_op("reserved7",  3'd7, 32'hdeadbeef, 32'h00000000, 32'h00000000, 1'b0, 2, 0);

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 5));
            rl  = $urandom;
            rr  = (i % 2 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            model(rop, rl, rr, mres, mdbz, mlat);
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, rl, rr, mres, mdbz, mlat, 0);
        end

        @(negedge clk);
        start = 1'b1; operation = 3'd0; leftOperand = 32'd1234; rightOperand = 32'hffff0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort dbz", 32'(divisionByZero), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort held_idle", 32'(busy | done), 32'd0);
        reset = 1'b1;
        run_op("after_abort", 3'd1, 32'd2, 32'd3, 32'h00000006, 1'b0, 34, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
